// File: rtl/blowfish128_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : blowfish128_pkg                                                |
// | Description: Shared widths, key-bank indices and host FSM state encoding.   |
// | Revision   : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package blowfish128_pkg;

  localparam int         NUM_KEYS    = 7;
  localparam int         KEY_W       = 64;
  localparam int         BLK_W       = 128;
  localparam int         KLEN_W      = 4;
  localparam logic [2:0] KEY_LEN_IDX = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/blowfish128_key_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : blowfish128_key_bank                                           |
// | Description: 7x64-bit key registers plus 4-bit key_length with one write    |
// |              port; read view forwards a same-cycle write.                   |
// | Revision   : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module blowfish128_key_bank
  import blowfish128_pkg::*;
(
  input  logic                      Clk,
  input  logic                      RstN,
  input  logic                      wr_en,
  input  logic [2:0]                wr_idx,
  input  logic [KEY_W-1:0]          wr_data,
  output logic [NUM_KEYS*KEY_W-1:0] rd_keys,
  output logic [KLEN_W-1:0]         rd_key_length
);

  logic [KLEN_W-1:0] r_klen;
  logic              w_klen_wr;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic [KEY_W-1:0] r_key;
    logic             w_wr;

    assign w_wr = wr_en && (wr_idx == 3'(i));

    always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
        r_key <= '0;
      end else if (w_wr) begin
        r_key <= wr_data;
      end
    end

    // Forwarding lets a snapshot taken in the write cycle see the new value.
    assign rd_keys[i*KEY_W +: KEY_W] = w_wr ? wr_data : r_key;
  end

  assign w_klen_wr = wr_en && (wr_idx == KEY_LEN_IDX);

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_klen <= '0;
    end else if (w_klen_wr) begin
      r_klen <= wr_data[KLEN_W-1:0];
    end
  end

  assign rd_key_length = w_klen_wr ? wr_data[KLEN_W-1:0] : r_klen;

endmodule
`default_nettype wire

// File: rtl/blowfish128_host_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : blowfish128_host_ctrl                                          |
// | Description: Host-side request/response driver for blowfish128_top's       |
// |              Enable/cipherReady handshake. Optional BF_HOST_TIMEOUT_EN      |
// |              adds a RUN watchdog that aborts with rsp_error.               |
// | Revision   : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module blowfish128_host_ctrl
  import blowfish128_pkg::*;
#(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               Clk,
  input  logic               RstN,
  input  logic               key_wr_en,
  input  logic [2:0]         key_wr_idx,
  input  logic [KEY_W-1:0]   key_wr_data,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [BLK_W-1:0]   req_data,
  input  logic               req_encrypt,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [BLK_W-1:0]   rsp_data,
  output logic               rsp_error,
  output logic               busy,
  output logic               core_enable,
  output logic               core_encrypt,
  output logic [BLK_W-1:0]   core_text,
  output logic [KEY_W-1:0]   core_key0,
  output logic [KEY_W-1:0]   core_key1,
  output logic [KEY_W-1:0]   core_key2,
  output logic [KEY_W-1:0]   core_key3,
  output logic [KEY_W-1:0]   core_key4,
  output logic [KEY_W-1:0]   core_key5,
  output logic [KEY_W-1:0]   core_key6,
  output logic [KLEN_W-1:0]  core_key_length,
  input  logic [BLK_W-1:0]   core_cipher,
  input  logic               core_ready
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  state_t                    r_state;
  logic                      r_rst_done;
  logic                      r_first;
  logic [GAP_W-1:0]          r_gap_cnt;
  logic                      r_core_enable;
  logic                      r_core_encrypt;
  logic [BLK_W-1:0]          r_core_text;
  logic [KEY_W-1:0]          r_core_key [NUM_KEYS];
  logic [KLEN_W-1:0]         r_core_klen;
  logic                      r_rsp_valid;
  logic                      r_rsp_error;
  logic [BLK_W-1:0]          r_rsp_data;

  logic [NUM_KEYS*KEY_W-1:0] w_bank_keys;
  logic [KLEN_W-1:0]         w_bank_klen;
  logic                      w_req_ready;
  logic                      w_accept;
  logic                      w_timeout;

  blowfish128_key_bank u_key_bank (
    .Clk           (Clk),
    .RstN          (RstN),
    .wr_en         (key_wr_en),
    .wr_idx        (key_wr_idx),
    .wr_data       (key_wr_data),
    .rd_keys       (w_bank_keys),
    .rd_key_length (w_bank_klen)
  );

  // r_rst_done holds req_ready low for the first edge after reset release.
  assign w_req_ready = r_rst_done && (r_state == IDLE);
  assign w_accept    = req_valid && w_req_ready;

`ifdef BF_HOST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_to_cnt <= '0;
    end else if (w_accept) begin
      r_to_cnt <= '0;
    end else if (r_state == RUN) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == RUN) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign w_timeout            = 1'b0;
`endif

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_state        <= IDLE;
      r_rst_done     <= 1'b0;
      r_first        <= 1'b0;
      r_gap_cnt      <= '0;
      r_core_enable  <= 1'b0;
      r_core_encrypt <= 1'b0;
      r_core_text    <= '0;
      r_core_klen    <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_error    <= 1'b0;
      r_rsp_data     <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_core_key[i] <= '0;
      end
    end else begin
      r_rst_done <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_core_text    <= req_data;
            r_core_encrypt <= req_encrypt;
            r_core_klen    <= w_bank_klen;
            for (int i = 0; i < NUM_KEYS; i++) begin
              r_core_key[i] <= w_bank_keys[i*KEY_W +: KEY_W];
            end
            r_core_enable  <= 1'b1;
            r_first        <= 1'b1;
            r_state        <= RUN;
          end
        end
        RUN: begin
          // cipherReady may still be high from the previous op in the first cycle.
          r_first <= 1'b0;
          if (!r_first && core_ready) begin
            r_rsp_data    <= core_cipher;
            r_rsp_error   <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_core_enable <= 1'b0;
            r_state       <= RESP;
          end else if (w_timeout) begin
            r_rsp_data    <= '0;
            r_rsp_error   <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_core_enable <= 1'b0;
            r_state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_gap_cnt   <= '0;
            r_state     <= GAP;
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready       = w_req_ready;
  assign busy            = (r_state != IDLE);
  assign rsp_valid       = r_rsp_valid;
  assign rsp_data        = r_rsp_data;
  assign rsp_error       = r_rsp_error;
  assign core_enable     = r_core_enable;
  assign core_encrypt    = r_core_encrypt;
  assign core_text       = r_core_text;
  assign core_key0       = r_core_key[0];
  assign core_key1       = r_core_key[1];
  assign core_key2       = r_core_key[2];
  assign core_key3       = r_core_key[3];
  assign core_key4       = r_core_key[4];
  assign core_key5       = r_core_key[5];
  assign core_key6       = r_core_key[6];
  assign core_key_length = r_core_klen;

endmodule
`default_nettype wire
